// File: rtl/mfp_ahb_pbintc_pkg.sv
// Shared definitions for the pushbutton interrupt controller: register offsets and decoder base.
package mfp_ahb_pbintc_pkg;

   localparam logic [31:0] PBINTC_BASE = 32'h1F80_1000;

   typedef enum logic [1:0] {
      PBINTC_RAW     = 2'd0,
      PBINTC_PENDING = 2'd1,
      PBINTC_MASK    = 2'd2,
      PBINTC_ACTIVE  = 2'd3
   } pbintc_reg_e;

endpackage

// File: rtl/mfp_pb_debounce.sv
// One pushbutton input: 2-flop synchronizer followed by a stability counter.
module mfp_pb_debounce #(
   parameter int unsigned DEB_CYCLES = 500000,
   parameter int unsigned DEB_W      = 20
) (
   input  logic HCLK,
   input  logic SI_Reset,
   input  logic din,
   output logic dout
);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [DEB_W-1:0] r_cnt;

   // stable only follows sync after DEB_CYCLES consecutive differing cycles
   always_ff @(posedge HCLK) begin
      if (SI_Reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_stable) begin
            if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
               r_stable <= r_sync2;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + DEB_W'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign dout = r_stable;

endmodule

// File: rtl/mfp_ahb_pbintc.sv
// AHB-Lite pushbutton interrupt controller: debounced raw view, rising-edge pending bits, mask, level IRQ.
module mfp_ahb_pbintc
   import mfp_ahb_pbintc_pkg::*;
#(
   parameter int unsigned N_SRC      = 5,
   parameter int unsigned DEB_CYCLES = 500000,
   parameter int unsigned DEB_W      = 20
) (
   input  logic             HCLK,
   input  logic             SI_Reset,
   input  logic             HSEL,
   input  logic [31:0]      HADDR,
   input  logic [1:0]       HTRANS,
   input  logic             HWRITE,
   input  logic             HREADY,
   input  logic [31:0]      HWDATA,
   output logic [31:0]      HRDATA,
   output logic             HREADYOUT,
   output logic             HRESP,
   input  logic [N_SRC-1:0] IO_PB,
   output logic             PB_IRQ
);

   logic [N_SRC-1:0] w_stable;
   logic [N_SRC-1:0] r_stable_d;
   logic [N_SRC-1:0] w_rise;
   logic [N_SRC-1:0] r_pending;
   logic [N_SRC-1:0] r_mask;
   logic [N_SRC-1:0] w_wdata;
   logic [N_SRC-1:0] w_w1c;
   logic             w_addr_ph;
   logic             r_wr_en;
   logic             r_rd_en;
   pbintc_reg_e      r_addr;
   logic             r_irq;
   logic [31:0]      w_rdata;
   logic             w_unused;

   for (genvar g = 0; g < int'(N_SRC); g++) begin : g_deb
      mfp_pb_debounce #(
         .DEB_CYCLES (DEB_CYCLES),
         .DEB_W      (DEB_W)
      ) u_deb (
         .HCLK     (HCLK),
         .SI_Reset (SI_Reset),
         .din      (IO_PB[g]),
         .dout     (w_stable[g])
      );
   end

   assign w_rise    = w_stable & ~r_stable_d;
   assign w_addr_ph = HSEL & HTRANS[1] & HREADY;
   assign w_wdata   = HWDATA[N_SRC-1:0];
   assign w_w1c     = (r_wr_en && (r_addr == PBINTC_PENDING)) ? w_wdata : '0;

   // address-phase capture, register file and interrupt output
   always_ff @(posedge HCLK) begin
      if (SI_Reset) begin
         r_stable_d <= '0;
         r_wr_en    <= 1'b0;
         r_rd_en    <= 1'b0;
         r_addr     <= PBINTC_RAW;
         r_pending  <= '0;
         r_mask     <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_stable_d <= w_stable;
         r_wr_en    <= w_addr_ph & HWRITE;
         r_rd_en    <= w_addr_ph & ~HWRITE;
         if (w_addr_ph) begin
            r_addr <= pbintc_reg_e'(HADDR[3:2]);
         end
         // a rise in the same cycle as its clear keeps the bit set
         r_pending <= (r_pending & ~w_w1c) | w_rise;
         if (r_wr_en && (r_addr == PBINTC_MASK)) begin
            r_mask <= w_wdata;
         end
         r_irq <= |(r_pending & r_mask);
      end
   end

   // read mux sees pre-update register values of the data-phase cycle
   always_comb begin
      w_rdata = '0;
      if (r_rd_en) begin
         case (r_addr)
            PBINTC_RAW:     w_rdata = 32'(w_stable);
            PBINTC_PENDING: w_rdata = 32'(r_pending);
            PBINTC_MASK:    w_rdata = 32'(r_mask);
            PBINTC_ACTIVE:  w_rdata = 32'(r_pending & r_mask);
            default:        w_rdata = '0;
         endcase
      end
   end

   assign HRDATA    = w_rdata;
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign PB_IRQ    = r_irq;

   assign w_unused = &{1'b0, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:N_SRC]};

endmodule

// File: tb/tb_mfp_ahb_pbintc.sv
// Directed bench for mfp_ahb_pbintc with a short debounce window.
module tb_mfp_ahb_pbintc;
   import mfp_ahb_pbintc_pkg::*;

   localparam int unsigned N_SRC      = 5;
   localparam int unsigned DEB_CYCLES = 4;
   localparam int unsigned DEB_W      = 20;

   logic             HCLK;
   logic             SI_Reset;
   logic             HSEL;
   logic [31:0]      HADDR;
   logic [1:0]       HTRANS;
   logic             HWRITE;
   logic             HREADY;
   logic [31:0]      HWDATA;
   logic [31:0]      HRDATA;
   logic             HREADYOUT;
   logic             HRESP;
   logic [N_SRC-1:0] IO_PB;
   logic             PB_IRQ;

   int n_chk;
   int n_bad;

   mfp_ahb_pbintc #(
      .N_SRC      (N_SRC),
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W)
   ) dut (
      .HCLK      (HCLK),
      .SI_Reset  (SI_Reset),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HREADY    (HREADY),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .IO_PB     (IO_PB),
      .PB_IRQ    (PB_IRQ)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HADDR  = 32'h0;
   endtask

   task automatic addr_ph(input logic wr, input logic [1:0] off);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = wr;
      HADDR  = {PBINTC_BASE[31:4], off, 2'b00};
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge HCLK);
   endtask

   task automatic ahb_wr(input logic [1:0] off, input logic [31:0] data);
      addr_ph(1'b1, off);
      @(negedge HCLK);
      bus_idle();
      HWDATA = data;
      @(negedge HCLK);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
      addr_ph(1'b0, off);
      @(negedge HCLK);
      check(tag, HRDATA, exp);
      check("hreadyout", 32'(HREADYOUT), 32'h1);
      check("hresp", 32'(HRESP), 32'h0);
      bus_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk    = 0;
      n_bad    = 0;
      SI_Reset = 1'b1;
      IO_PB    = '0;
      HREADY   = 1'b1;
      HWDATA   = 32'h0;
      bus_idle();
      cyc(3);
      check("rst_irq", 32'(PB_IRQ), 32'h0);
      SI_Reset = 1'b0;

      // reset values
      rd_chk("t1_raw",     PBINTC_RAW,     32'h0);
      rd_chk("t1_pending", PBINTC_PENDING, 32'h0);
      rd_chk("t1_mask",    PBINTC_MASK,    32'h0);
      rd_chk("t1_active",  PBINTC_ACTIVE,  32'h0);
      check("t1_irq", 32'(PB_IRQ), 32'h0);

      // clean step on bit 0: RAW changes exactly at edge 6
      IO_PB = 5'b00001;
      addr_ph(1'b0, PBINTC_RAW);
      for (int k = 1; k <= 6; k++) begin
         @(negedge HCLK);
         if (k == 5) check("t2_raw_k5", HRDATA, 32'h0);
         if (k == 6) check("t2_raw_k6", HRDATA, 32'h1);
      end
      addr_ph(1'b0, PBINTC_PENDING);
      @(negedge HCLK);
      check("t2_pending_k7", HRDATA, 32'h1);
      bus_idle();
      cyc(3);
      check("t2_irq_unmasked", 32'(PB_IRQ), 32'h0);
      ahb_wr(PBINTC_MASK, 32'h1);
      check("t2_irq_wr_edge", 32'(PB_IRQ), 32'h0);
      @(negedge HCLK);
      check("t2_irq_set", 32'(PB_IRQ), 32'h1);
      rd_chk("t2_active", PBINTC_ACTIVE, 32'h1);

      // 3-cycle glitch on bit 1 is rejected
      IO_PB = 5'b00011;
      cyc(3);
      IO_PB = 5'b00001;
      for (int k = 0; k < 8; k++) begin
         @(negedge HCLK);
         check("t3_irq_hold", 32'(PB_IRQ), 32'h1);
      end
      rd_chk("t3_raw",     PBINTC_RAW,     32'h1);
      rd_chk("t3_pending", PBINTC_PENDING, 32'h1);

      // write-1-to-clear, IRQ drops one cycle later
      ahb_wr(PBINTC_PENDING, 32'h1);
      check("t4_irq_w1c_edge", 32'(PB_IRQ), 32'h1);
      rd_chk("t4_pending_clr", PBINTC_PENDING, 32'h0);
      check("t4_irq_clr", 32'(PB_IRQ), 32'h0);
      IO_PB = 5'b00000;
      cyc(10);
      rd_chk("t4_raw_fall",     PBINTC_RAW,     32'h0);
      rd_chk("t4_pending_fall", PBINTC_PENDING, 32'h0);
      // rise lands on the same edge as the W1C write
      IO_PB = 5'b00001;
      cyc(5);
      ahb_wr(PBINTC_PENDING, 32'h1);
      rd_chk("t4_set_wins", PBINTC_PENDING, 32'h1);
      check("t4_irq_reset", 32'(PB_IRQ), 32'h1);

      // back-to-back write then read of MASK
      addr_ph(1'b1, PBINTC_MASK);
      @(negedge HCLK);
      HWDATA = 32'h0000_001F;
      addr_ph(1'b0, PBINTC_MASK);
      @(negedge HCLK);
      check("t5_b2b_mask", HRDATA, 32'h1F);
      bus_idle();
      ahb_wr(PBINTC_RAW, 32'hFFFF_FFFF);
      rd_chk("t5_raw_ro", PBINTC_RAW, 32'h1);
      ahb_wr(PBINTC_ACTIVE, 32'hFFFF_FFFF);
      rd_chk("t5_active_ro", PBINTC_ACTIVE, 32'h1);
      ahb_wr(PBINTC_MASK, 32'hFFFF_FFE2);
      rd_chk("t5_mask_upper", PBINTC_MASK, 32'h2);
      ahb_wr(PBINTC_MASK, 32'h1F);

      // reset while all buttons are held
      IO_PB = 5'h1F;
      cyc(10);
      rd_chk("t6_raw_pre",     PBINTC_RAW,     32'h1F);
      rd_chk("t6_pending_pre", PBINTC_PENDING, 32'h1F);
      check("t6_irq_pre", 32'(PB_IRQ), 32'h1);
      SI_Reset = 1'b1;
      cyc(2);
      check("t6_irq_rst", 32'(PB_IRQ), 32'h0);
      SI_Reset = 1'b0;
      addr_ph(1'b0, PBINTC_MASK);
      @(negedge HCLK);
      check("t6_mask_k1", HRDATA, 32'h0);
      addr_ph(1'b0, PBINTC_PENDING);
      @(negedge HCLK);
      check("t6_pending_k2", HRDATA, 32'h0);
      addr_ph(1'b0, PBINTC_ACTIVE);
      @(negedge HCLK);
      check("t6_active_k3", HRDATA, 32'h0);
      addr_ph(1'b0, PBINTC_RAW);
      @(negedge HCLK);
      check("t6_raw_k4", HRDATA, 32'h0);
      @(negedge HCLK);
      check("t6_raw_k5", HRDATA, 32'h0);
      @(negedge HCLK);
      check("t6_raw_k6", HRDATA, 32'h1F);
      addr_ph(1'b0, PBINTC_PENDING);
      @(negedge HCLK);
      check("t6_pending_k7", HRDATA, 32'h1F);
      bus_idle();
      check("t6_irq_k7", 32'(PB_IRQ), 32'h0);
      cyc(3);
      check("t6_irq_nomask", 32'(PB_IRQ), 32'h0);
      ahb_wr(PBINTC_MASK, 32'h1F);
      check("t6_irq_wr_edge", 32'(PB_IRQ), 32'h0);
      @(negedge HCLK);
      check("t6_irq_set", 32'(PB_IRQ), 32'h1);

      // partial clear leaves unwritten bits alone
      ahb_wr(PBINTC_PENDING, 32'h05);
      rd_chk("t6_pending_part", PBINTC_PENDING, 32'h1A);
      rd_chk("t6_active_part",  PBINTC_ACTIVE,  32'h1A);
      check("t6_irq_part", 32'(PB_IRQ), 32'h1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
